// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: synchronises and debounces four active-low buttons and
// applies at most one saturating position step per FRAMES_PER_STEP frames, at vsync start.
module sprite_motion_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPRITE_SIZE     = 50,
  parameter int X_INIT          = 200,
  parameter int Y_INIT          = 200,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 1,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic [18:0] oX,
  output logic [18:0] oY,
  output logic        oUpdate,
  output logic        oMoving
);

  localparam int POS_W = 19;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [POS_W-1:0] X_MAX   = POS_W'(SCREEN_W - SPRITE_SIZE);
  localparam logic [POS_W-1:0] Y_MAX   = POS_W'(SCREEN_H - SPRITE_SIZE);
  localparam logic [POS_W-1:0] STEP_V  = POS_W'(STEP);
  localparam logic [POS_W-1:0] X_RST   = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_RST   = POS_W'(Y_INIT);

  typedef enum logic {
    WAIT_VS = 1'b0,
    APPLY   = 1'b1
  } state_t;

  function automatic logic [POS_W-1:0] sat_dec(input logic [POS_W-1:0] v);
    return (v < STEP_V) ? '0 : (v - STEP_V);
  endfunction

  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v,
                                               input logic [POS_W-1:0] lim);
    logic [POS_W:0] sum;
    sum = {1'b0, v} + {1'b0, STEP_V};
    return (sum > {1'b0, lim}) ? lim : sum[POS_W-1:0];
  endfunction

  // Button vectors are ordered {up, down, left, right}, active-low.
  logic [3:0]      btn_s1_q, btn_s1_d;
  logic [3:0]      btn_s2_q, btn_s2_d;
  logic [3:0]      btn_db_q, btn_db_d;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];

  logic            vs_s1_q, vs_s1_d;
  logic            vs_s2_q, vs_s2_d;
  logic            vs_dly_q, vs_dly_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

  state_t          state_q, state_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d;
  logic [POS_W-1:0] pos_y_q, pos_y_d;
  logic            update_q, update_d;
  logic            moving_q, moving_d;

  logic [3:0]      press;
  logic            any_press;
  logic            tick;
  logic            go;
  logic [POS_W-1:0] next_x;
  logic [POS_W-1:0] next_y;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_s1_q    <= 4'hF;
      btn_s2_q    <= 4'hF;
      btn_db_q    <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      vs_s1_q     <= 1'b1;
      vs_s2_q     <= 1'b1;
      vs_dly_q    <= 1'b1;
      frame_cnt_q <= '0;
      state_q     <= WAIT_VS;
      pos_x_q     <= X_RST;
      pos_y_q     <= Y_RST;
      update_q    <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_db_q    <= btn_db_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      vs_s1_q     <= vs_s1_d;
      vs_s2_q     <= vs_s2_d;
      vs_dly_q    <= vs_dly_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      update_q    <= update_d;
      moving_q    <= moving_d;
    end
  end

  // A change is accepted only after the synced value has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    btn_s1_d = {up, down, left, right};
    btn_s2_d = btn_s1_q;
    btn_db_d = btn_db_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != btn_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          btn_db_d[i] = btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press     = ~btn_db_q;
  assign any_press = |press;

  // Frame tick on the falling edge of the synchronised vsync.
  always_comb begin
    vs_s1_d  = iVS;
    vs_s2_d  = vs_s1_q;
    vs_dly_d = vs_s2_q;
    tick     = vs_dly_q & ~vs_s2_q;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    go          = 1'b0;
    if (!any_press) begin
      frame_cnt_d = '0;
    end else if (tick) begin
      if (frame_cnt_q == FC_LAST) begin
        go          = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Opposing presses on one axis cancel; the two axes are independent.
  always_comb begin
    next_x = pos_x_q;
    next_y = pos_y_q;
    if (press[1] && !press[0]) begin
      next_x = sat_dec(pos_x_q);
    end else if (press[0] && !press[1]) begin
      next_x = sat_inc(pos_x_q, X_MAX);
    end
    if (press[3] && !press[2]) begin
      next_y = sat_dec(pos_y_q);
    end else if (press[2] && !press[3]) begin
      next_y = sat_inc(pos_y_q, Y_MAX);
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    update_d = 1'b0;
    moving_d = any_press;
    case (state_q)
      WAIT_VS: begin
        if (tick && go) state_d = APPLY;
      end
      APPLY: begin
        pos_x_d  = next_x;
        pos_y_d  = next_y;
        update_d = (next_x != pos_x_q) || (next_y != pos_y_q);
        state_d  = WAIT_VS;
      end
      default: state_d = WAIT_VS;
    endcase
  end

  assign oX      = pos_x_q;
  assign oY      = pos_y_q;
  assign oUpdate = update_q;
  assign oMoving = moving_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed vector table, hand-written frame sequences,
// and randomized stimulus compared against a history-based reference model.
module tb_sprite_motion_ctrl;

  localparam int FPS  = 2;
  localparam int XMAX = 590;
  localparam int YMAX = 430;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ivs   = 1'b1;
  logic        b_up = 1'b1, b_down = 1'b1, b_left = 1'b1, b_right = 1'b1;
  logic [18:0] ox, oy;
  logic        oupd, omov;

  int n_checks = 0;
  int n_pass   = 0;
  int upd_total = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .SCREEN_W(640), .SCREEN_H(480), .SPRITE_SIZE(50), .X_INIT(200), .Y_INIT(200),
    .STEP(1), .FRAMES_PER_STEP(FPS), .DEBOUNCE_CYCLES(4)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(ivs),
    .up(b_up), .down(b_down), .left(b_left), .right(b_right),
    .oX(ox), .oY(oy), .oUpdate(oupd), .oMoving(omov)
  );

  always @(negedge clk) if (oupd) upd_total <= upd_total + 1;

  // Reference model: state after each clock edge, built from input histories.
  typedef struct packed {
    logic [3:0]  raw1;    // buttons sampled at the previous edge
    logic [15:0] sync_h;  // nibble k = synced buttons k+1 edges ago
    logic [3:0]  db;
    logic [2:0]  vs_h;    // bit k = iVS sampled k+1 edges ago
    logic [31:0] ticks;
    logic        apply;
    logic [18:0] x;
    logic [18:0] y;
    logic        upd;
    logic        moving;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.raw1 = 4'hF; n.sync_h = 16'hFFFF; n.db = 4'hF; n.vs_h = 3'b111;
    n.ticks = 0; n.apply = 1'b0; n.x = 19'd200; n.y = 19'd200;
    n.upd = 1'b0; n.moving = 1'b0;
    return n;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic model_t model_step(input model_t s, input logic [3:0] raw, input logic vs);
    model_t n;
    logic   all_diff;
    logic   tick;
    int     dx, dy, nx, ny;
    n = s;
    n.raw1   = raw;
    n.sync_h = {s.sync_h[11:0], s.raw1};
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < 4; k++) if (s.sync_h[4*k+b] == s.db[b]) all_diff = 1'b0;
      if (all_diff) n.db[b] = ~s.db[b];
    end
    n.moving = (s.db != 4'hF);
    tick     = s.vs_h[2] & ~s.vs_h[1];
    n.vs_h   = {s.vs_h[1:0], vs};
    n.apply  = 1'b0;
    if (s.db == 4'hF) n.ticks = 0;
    else if (tick) begin
      if (s.ticks + 1 == FPS) begin n.apply = 1'b1; n.ticks = 0; end
      else n.ticks = s.ticks + 1;
    end
    n.upd = 1'b0;
    if (s.apply) begin
      dx = (s.db[0] ? 0 : 1) - (s.db[1] ? 0 : 1);
      dy = (s.db[2] ? 0 : 1) - (s.db[3] ? 0 : 1);
      nx = clamp(int'(s.x) + dx, XMAX);
      ny = clamp(int'(s.y) + dy, YMAX);
      n.upd = (nx != int'(s.x)) || (ny != int'(s.y));
      n.x = 19'(nx);
      n.y = 19'(ny);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, {b_up, b_down, b_left, b_right}, ivs);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] mask);
    {b_up, b_down, b_left, b_right} = ~mask;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_btn(4'h0);
    ivs = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic frame(input int len);
    ivs = 1'b1;
    repeat (len - 2) cyc();
    ivs = 1'b0;
    cyc();
    cyc();
    ivs = 1'b1;
  endtask

  // Frame whose vsync fall is followed edge by edge; edge 4 carries any position update.
  task automatic frame_edge(input int len, input int prev_x, input int exp_x,
                            input logic exp_upd, input string nm);
    ivs = 1'b1;
    repeat (len - 2) cyc();
    ivs = 1'b0;
    cyc();
    cyc();
    ivs = 1'b1;
    cyc();
    chk({nm, "_e3_upd"}, oupd, 0);
    chk({nm, "_e3_x"}, ox, prev_x);
    cyc();
    chk({nm, "_e4_x"}, ox, exp_x);
    chk({nm, "_e4_upd"}, oupd, exp_upd);
    cyc();
    chk({nm, "_e5_upd"}, oupd, 0);
  endtask

  task automatic hold(input logic [3:0] mask, input int n, input int len,
                      output int upd, output logic mov);
    int base;
    base = upd_total;
    set_btn(mask);
    frame(len);
    mov = omov;
    repeat (n - 1) frame(len);
    set_btn(4'h0);
    frame(len);
    upd = upd_total - base;
  endtask

  typedef struct {
    logic [3:0] mask;   // {up, down, left, right}, 1 = pressed
    int         frames;
    int         ex;
    int         ey;
    int         eupd;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   upd, got, hlo_hi, hlo_lo, fpos, hold_left;
    logic mov;
    logic [3:0] rmask;

    tbl[0] = '{4'b0001, 4, 202, 200, 2};
    tbl[1] = '{4'b1101, 4, 204, 200, 2};
    tbl[2] = '{4'b1010, 2, 203, 199, 1};
    tbl[3] = '{4'b0101, 6, 206, 202, 3};
    tbl[4] = '{4'b0011, 4, 206, 202, 0};
    tbl[5] = '{4'b1000, 3, 206, 201, 1};
    tbl[6] = '{4'b1111, 2, 206, 201, 0};
    tbl[7] = '{4'b0110, 4, 204, 203, 2};

    // Reset values appear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x", ox, 200);
    chk("rst_y", oy, 200);
    chk("rst_upd", oupd, 0);
    chk("rst_mov", omov, 0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Vector table, each entry followed by a release frame.
    frame(24);
    for (int i = 0; i < 8; i++) begin
      hold(tbl[i].mask, tbl[i].frames, 24, upd, mov);
      chk($sformatf("tbl%0d_x", i), ox, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), oy, tbl[i].ey);
      chk($sformatf("tbl%0d_upd", i), upd, tbl[i].eupd);
      chk($sformatf("tbl%0d_mov", i), mov, 1);
      chk($sformatf("tbl%0d_mov_rel", i), omov, 0);
    end

    // Debounce: a 3-cycle glitch is ignored, a steady press is accepted after 7 edges.
    do_reset();
    got = upd_total;
    b_right = 1'b0;
    repeat (3) cyc();
    b_right = 1'b1;
    chk("glitch_mov_a", omov, 0);
    repeat (3) frame(800);
    chk("glitch_mov_b", omov, 0);
    chk("glitch_x", ox, 200);
    chk("glitch_upd", upd_total - got, 0);
    b_right = 1'b0;
    got = 0;
    for (int k = 1; k <= 20 && got == 0; k++) begin
      cyc();
      if (omov) got = k;
    end
    chk("mov_latency", got, 7);
    frame_edge(800, 200, 200, 1'b0, "tick1");
    frame_edge(800, 200, 201, 1'b1, "tick2");
    frame_edge(800, 201, 201, 1'b0, "tick3");
    frame_edge(800, 201, 202, 1'b1, "tick4");

    // Asynchronous reset mid-frame with right still held.
    repeat (10) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", ox, 200);
    chk("arst_y", oy, 200);
    chk("arst_upd", oupd, 0);
    chk("arst_mov", omov, 0);
    b_right = 1'b1;
    b_left  = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    got = upd_total;
    frame(24);
    frame(24);
    chk("recov_x_early", ox, 200);
    chk("recov_upd_early", upd_total - got, 0);
    frame(24);
    chk("recov_x", ox, 199);
    chk("recov_upd", upd_total - got, 1);

    // Releasing mid-count restarts the frame count.
    do_reset();
    frame(24);
    b_right = 1'b0;
    frame(24);
    b_right = 1'b1;
    frame(24);
    b_right = 1'b0;
    frame(24);
    repeat (3) cyc();
    chk("release_first_tick_x", ox, 200);
    frame(24);
    repeat (3) cyc();
    chk("release_second_tick_x", ox, 201);
    b_right = 1'b1;

    // Clamps at the bottom and top edges.
    do_reset();
    frame(16);
    hold(4'b0100, 500, 16, upd, mov);
    chk("clamp_down_y", oy, 430);
    chk("clamp_down_upd", upd, 230);
    chk("clamp_down_x", ox, 200);
    hold(4'b1000, 900, 16, upd, mov);
    chk("clamp_up_y", oy, 0);
    chk("clamp_up_upd", upd, 430);

    // Randomized stimulus against the reference model, with one reset in the middle.
    do_reset();
    fpos = 0; hlo_hi = 20; hlo_lo = 2; hold_left = 0; rmask = 4'h0;
    for (int c = 0; c < 6000; c++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 3))
          0:       begin rmask = 4'h0; hold_left = $urandom_range(1, 30); end
          1:       begin rmask = 4'($urandom_range(1, 15)); hold_left = $urandom_range(40, 200); end
          default: begin rmask = 4'($urandom_range(1, 15)); hold_left = $urandom_range(1, 12); end
        endcase
      end
      hold_left--;
      set_btn(rmask);
      ivs = (fpos < hlo_hi) ? 1'b1 : 1'b0;
      fpos++;
      if (fpos == hlo_hi + hlo_lo) begin
        fpos = 0;
        hlo_hi = $urandom_range(8, 30);
        hlo_lo = $urandom_range(1, 3);
      end
      if (c == 3000) rst_n = 1'b0;
      if (c == 3003) rst_n = 1'b1;
      cyc();
      chk($sformatf("model_c%0d", c), {ox, oy, oupd, omov}, {m.x, m.y, m.upd, m.moving});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Position controller for the movable 50x50 sprite overlay in the 640x480 VGA pipeline.
- Synchronises and debounces the four active-low direction buttons.
- Applies at most one bounded position step per N frames, only at the start of vertical sync, so the pixel datapath never sees a mid-frame position change.
- Drives sprite X/Y into the pixel-compare stage of the VGA controller; replaces the free-running cycle counter as the motion sequencer.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
SPRITE_SIZE, 50, sprite edge length in pixels
X_INIT, 200, reset X position
Y_INIT, 200, reset Y position
STEP, 1, pixels moved per applied step
FRAMES_PER_STEP, 1, frame ticks between applied steps (>=1)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button change (>=2)

Ports:
iVGA_CLK  input  1  pixel clock; all logic on the rising edge
iRST_n  input  1  asynchronous active-low reset
iVS  input  1  vertical sync from the sync generator, active-low
up  input  1  raw button, active-low (0 = pressed)
down  input  1  raw button, active-low
left  input  1  raw button, active-low
right  input  1  raw button, active-low
oX  output  19  sprite top-left X
oY  output  19  sprite top-left Y
oUpdate  output  1  one-cycle pulse when oX or oY changed
oMoving  output  1  1 while any debounced direction is pressed

Behaviour:
- Reset (async, iRST_n=0), effective immediately:
  - oX=X_INIT, oY=Y_INIT, oUpdate=0, oMoving=0.
  - All synchroniser flops and debounced button states = 1 (released).
  - Debounce counters = 0, frame counter = 0, FSM = WAIT_VS.
  - Reset mid-step discards the step.
- Buttons:
  - Each button passes through a 2-flop synchroniser.
  - Per-button debounce counter: if the synced value equals the debounced value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synced value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Frame tick:
  - iVS passes through a 2-flop synchroniser, plus a third delay flop.
  - tick = delayed==1 && synced==0 (falling edge). Exactly one tick per frame.
- Frame counter:
  - Cleared while no debounced direction is pressed.
  - On a tick with any direction pressed: if count==FRAMES_PER_STEP-1, assert go and clear; else increment.
- FSM:
  - WAIT_VS: on tick&&go -> APPLY; otherwise stay.
  - APPLY (exactly 1 cycle): register new oX/oY; -> WAIT_VS.
- Arithmetic in APPLY, 19-bit unsigned, saturating:
  - up only: oY = (oY<STEP) ? 0 : oY-STEP.
  - down only: oY = min(oY+STEP, SCREEN_H-SPRITE_SIZE), i.e. 430 by default.
  - left only: oX = (oX<STEP) ? 0 : oX-STEP.
  - right only: oX = min(oX+STEP, SCREEN_W-SPRITE_SIZE), i.e. 590 by default.
  - up+down together, or left+right together: that axis is unchanged.
  - Horizontal and vertical axes move in the same APPLY (diagonal allowed).
- Timing and outputs:
  - oUpdate=1 for the cycle after APPLY only if the new value differs from the old one (no pulse at a clamp limit).
  - Latency: the first rising edge sampling iVS=0 is edge 1. With go true, oX/oY/oUpdate change on edge 4.
  - oX/oY are constant at all other times.
  - oMoving = registered OR of the debounced presses, one cycle after the debounced change.
- A tick arriving while in APPLY cannot occur (ticks are a frame apart). No queuing is required.

Test Plan:
- Common setup: DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=2, STEP=1, frame = 800 cycles with iVS low for 2 cycles.
- Reset: assert iRST_n=0 mid-frame with right held -> oX=200, oY=200, oUpdate=0, oMoving=0 in the same cycle, with no clock edge needed.
- Debounce: pulse right=0 for 3 cycles -> oMoving stays 0, no movement over 3 frames. Hold right=0 -> oMoving=1 after 2+4+1 cycles, oX=201 at the 2nd tick, 202 at the 4th tick, each with a 1-cycle oUpdate on edge 4 after iVS falls.
- Clamp: preload down held for 500 frames from Y=200 -> oY stops at 430, no oUpdate after reaching 430. Preload up -> oY stops at 0.
- Conflict/diagonal: up+down+right held -> oY unchanged, oX increments by 1 per 2 frames. Up+left held from (200,200) -> (199,199) after 2 frames.
- Release: release all directions mid-count (after 1 tick) -> frame counter clears. A new press moves on the 2nd tick after the press, not the 1st.
- Reset recovery: deassert reset, hold left -> first step X=199 occurs only after debounce plus 2 ticks, with no spurious oUpdate.
